// File: rtl/kernel_pr_write_back_stage.sv
// PageRank write-back stage: pops a start token, then streams rank words to memory as
// single-outstanding write bursts. Optional statistics counter: KERNEL_PR_WB_STATS_EN.
module kernel_pr_write_back_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_words,
  input  logic                  start_empty_n,
  output logic                  start_read,
  input  logic                  din_empty_n,
  input  logic [DATA_WIDTH-1:0] din_dout,
  output logic                  din_read,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [7:0]            awlen,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wlast,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  output logic                  done,
  output logic                  idle,
  output logic                  err,
  output logic [CNT_WIDTH-1:0]  total_words
);

  localparam int unsigned BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int unsigned LEN_WIDTH      = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [CNT_WIDTH-1:0]  r_remaining;
  logic [7:0]            r_awlen;
  logic [7:0]            r_beat;
  logic                  r_err;

  logic                  w_start_fire;
  logic                  w_aw_fire;
  logic                  w_w_fire;
  logic                  w_b_fire;
  logic                  w_beat_last;
  logic [LEN_WIDTH-1:0]  w_len;

  // Beats-minus-one of the next burst for a given number of words still to write.
  function automatic logic [7:0] awlen_of(input logic [CNT_WIDTH-1:0] rem);
    if (rem >= CNT_WIDTH'(BURST_LEN)) begin
      return 8'(BURST_LEN - 1);
    end
    return 8'(rem - CNT_WIDTH'(1));
  endfunction

  always_comb begin
    w_start_fire = (r_state == S_IDLE) && start_empty_n && !reset;
    w_aw_fire    = (r_state == S_ADDR) && awready;
    w_beat_last  = (r_state == S_DATA) && (r_beat == r_awlen);
    w_w_fire     = (r_state == S_DATA) && din_empty_n && wready;
    w_b_fire     = (r_state == S_RESP) && bvalid;
    w_len        = LEN_WIDTH'(r_awlen) + LEN_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    start_read   = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    din_read     = 1'b0;
    wlast        = 1'b0;
    bready       = 1'b0;
    done         = 1'b0;
    idle         = 1'b0;
    case (r_state)
      S_IDLE: begin
        idle       = 1'b1;
        start_read = start_empty_n && !reset;
        if (w_start_fire) begin
          w_state_next = (num_words == '0) ? S_DONE : S_ADDR;
        end
      end
      S_ADDR: begin
        awvalid = 1'b1;
        if (w_aw_fire) begin
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        wvalid   = din_empty_n;
        din_read = w_w_fire;
        wlast    = w_beat_last;
        if (w_w_fire && w_beat_last) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        bready = 1'b1;
        if (w_b_fire) begin
          w_state_next = (r_remaining == '0) ? S_DONE : S_ADDR;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Job bookkeeping; the burst length is fixed whenever ADDR is entered so AW stays stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_awlen     <= '0;
      r_beat      <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_fire) begin
            r_cur_addr  <= base_addr;
            r_remaining <= num_words;
            if (num_words != '0) begin
              r_awlen <= awlen_of(num_words);
            end
          end
        end
        S_ADDR: begin
          if (w_aw_fire) begin
            r_beat <= '0;
          end
        end
        S_DATA: begin
          if (w_w_fire) begin
            r_beat <= r_beat + 8'd1;
            if (w_beat_last) begin
              r_remaining <= r_remaining - CNT_WIDTH'(w_len);
              r_cur_addr  <= r_cur_addr + ADDR_WIDTH'(w_len) * ADDR_WIDTH'(BYTES_PER_WORD);
            end
          end
        end
        S_RESP: begin
          if (w_b_fire) begin
            if (bresp != 2'b00) begin
              r_err <= 1'b1;
            end
            if (r_remaining != '0) begin
              r_awlen <= awlen_of(r_remaining);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign awaddr = r_cur_addr;
  assign awlen  = r_awlen;
  assign wdata  = din_dout;
  assign err    = r_err;

`ifdef KERNEL_PR_WB_STATS_EN
  logic [CNT_WIDTH-1:0] r_total_words;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_total_words <= '0;
    end else if (w_w_fire) begin
      r_total_words <= r_total_words + CNT_WIDTH'(1);
    end
  end

  assign total_words = r_total_words;
`else
  assign total_words = '0;
`endif

endmodule
